// File: rtl/execute_stage.sv
// EX stage: operand forwarding, barrel shifter / immediate rotator, ALU with NZCV flags,
// branch target generation and the EX/MEM pipeline register.
module execute_stage (
    input  logic        clk,
    input  logic        rst,
    input  logic        writeBackEnabled,
    input  logic        memoryReadEnabled,
    input  logic        memoryWriteEnabled,
    input  logic        b,
    input  logic        s,
    input  logic [3:0]  executionCommand,
    input  logic [31:0] pc,
    input  logic [31:0] valRn,
    input  logic [31:0] valRm,
    input  logic        imm,
    input  logic [11:0] shiftOperand,
    input  logic [23:0] imm24,
    input  logic [3:0]  destination,
    input  logic        freeze,
    input  logic [1:0]  selSrc1,
    input  logic [1:0]  selSrc2,
    input  logic [31:0] memFwdValue,
    input  logic [31:0] wbFwdValue,
    output logic        branchTaken,
    output logic [31:0] branchAddress,
    output logic [3:0]  status,
    output logic        writeBackEnabledOut,
    output logic        memoryReadEnabledOut,
    output logic        memoryWriteEnabledOut,
    output logic [31:0] aluResult,
    output logic [31:0] valRmOut,
    output logic [3:0]  destinationOut
);

    logic [31:0] op_a;
    logic [31:0] fwd_rm;
    logic [31:0] shifted;
    logic [31:0] imm_base;
    logic [31:0] imm_val;
    logic [31:0] val2;
    logic [4:0]  shift_amt;
    logic [4:0]  rot_amt;
    logic [32:0] sum;
    logic [31:0] alu_res;
    logic        c_next;
    logic        v_next;
    logic [3:0]  flags_next;

    assign branchTaken   = b;
    assign branchAddress = pc + {{6{imm24[23]}}, imm24, 2'b00};

    always_comb begin
        case (selSrc1)
            2'b01:   op_a = memFwdValue;
            2'b10:   op_a = wbFwdValue;
            default: op_a = valRn;
        endcase
        case (selSrc2)
            2'b01:   fwd_rm = memFwdValue;
            2'b10:   fwd_rm = wbFwdValue;
            default: fwd_rm = valRm;
        endcase
    end

    // Rotations use a complementary left shift; a shift by 32 yields 0, so amount 0 is a pass-through.
    assign shift_amt = shiftOperand[11:7];
    assign rot_amt   = {shiftOperand[11:8], 1'b0};
    assign imm_base  = {24'b0, shiftOperand[7:0]};
    assign imm_val   = (imm_base >> rot_amt) | (imm_base << (6'd32 - {1'b0, rot_amt}));

    always_comb begin
        case (shiftOperand[6:5])
            2'b00:   shifted = fwd_rm << shift_amt;
            2'b01:   shifted = fwd_rm >> shift_amt;
            2'b10:   shifted = $unsigned($signed(fwd_rm) >>> shift_amt);
            default: shifted = (fwd_rm >> shift_amt) | (fwd_rm << (6'd32 - {1'b0, shift_amt}));
        endcase
    end

    always_comb begin
        if (memoryReadEnabled || memoryWriteEnabled)
            val2 = {20'b0, shiftOperand};
        else if (imm)
            val2 = imm_val;
        else
            val2 = shifted;
    end

    // Subtraction is A + ~B + carry-in, so carry-out is directly the "no borrow" flag.
    always_comb begin
        sum     = '0;
        alu_res = '0;
        c_next  = status[1];
        v_next  = status[0];
        case (executionCommand)
            4'b0001: alu_res = val2;
            4'b1001: alu_res = ~val2;
            4'b0010, 4'b0011: begin
                sum     = {1'b0, op_a} + {1'b0, val2}
                        + {32'b0, (executionCommand[0] & status[1])};
                alu_res = sum[31:0];
                c_next  = sum[32];
                v_next  = (op_a[31] == val2[31]) && (alu_res[31] != op_a[31]);
            end
            4'b0100, 4'b0101: begin
                sum     = {1'b0, op_a} + {1'b0, ~val2}
                        + {32'b0, (executionCommand[0] ? status[1] : 1'b1)};
                alu_res = sum[31:0];
                c_next  = sum[32];
                v_next  = (op_a[31] != val2[31]) && (alu_res[31] != op_a[31]);
            end
            4'b0110: alu_res = op_a & val2;
            4'b0111: alu_res = op_a | val2;
            4'b1000: alu_res = op_a ^ val2;
            default: alu_res = '0;
        endcase
        flags_next = {alu_res[31], (alu_res == 32'b0), c_next, v_next};
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            status                <= '0;
            writeBackEnabledOut   <= 1'b0;
            memoryReadEnabledOut  <= 1'b0;
            memoryWriteEnabledOut <= 1'b0;
            aluResult             <= '0;
            valRmOut              <= '0;
            destinationOut        <= '0;
        end else if (!freeze) begin
            if (s)
                status <= flags_next;
            writeBackEnabledOut   <= writeBackEnabled;
            memoryReadEnabledOut  <= memoryReadEnabled;
            memoryWriteEnabledOut <= memoryWriteEnabled;
            aluResult             <= alu_res;
            valRmOut              <= fwd_rm;
            destinationOut        <= destination;
        end
    end

endmodule
